// File: rtl/dna_pattern_search.sv
// dna_pattern_search
//
// Scans a nucleotide sequence held in an external synchronous-read memory
// (2 bits per nucleotide, one nucleotide per address) for a PAT_LEN-nucleotide
// pattern. It can stop at the first match or scan the whole sequence. Matches
// may overlap and are all counted. The position of the first match is reported.
// Requests whose length is shorter than the pattern, or whose range runs past
// the top of the address space, are rejected without touching memory.
//
// Ports:
//   clock, reset_N   rising-edge clock, asynchronous active-low reset
//   ready            start request, sampled in IDLE; must drop in DONE before
//                    another search can be accepted
//   find_all         0 = stop at first match, 1 = scan the whole sequence
//   dna_start        address of nucleotide 0
//   dna_length       number of nucleotides to scan
//   pattern          bits [1:0] = last nucleotide, MS pair = first nucleotide
//   mem_addr/mem_re  read request to the sequence memory
//   mem_data         read data, valid exactly one cycle after mem_re
//   done             search complete (held while in DONE)
//   found_it         at least one match found
//   error            request rejected
//   match_pos        address of the first nucleotide of the first match
//   match_count      number of matches (overlaps included), saturating
//   fsm_state        current FSM state, for observation only
//
// Memory handshake: mem_re=1 in a cycle is a read of mem_addr. The memory
// never stalls, and mem_data holds that nucleotide for exactly the following
// cycle. There is no ready/backpressure signal on this interface. mem_re also
// depends on mem_data through the match compare, so that a first-match stop
// withdraws the read that would otherwise go out in the same cycle.
module dna_pattern_search #(
  parameter int ADDR_W  = 16,
  parameter int PAT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                   clock,
  input  logic                   reset_N,
  input  logic                   ready,
  input  logic                   find_all,
  input  logic [ADDR_W-1:0]      dna_start,
  input  logic [ADDR_W-1:0]      dna_length,
  input  logic [2*PAT_LEN-1:0]   pattern,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_re,
  input  logic [1:0]             mem_data,
  output logic                   done,
  output logic                   found_it,
  output logic                   error,
  output logic [ADDR_W-1:0]      match_pos,
  output logic [CNT_W-1:0]       match_count,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The window keeps the previous PAT_LEN-1 nucleotides; the incoming one
  // completes the word being compared.
  localparam int                WIN_W     = 2*PAT_LEN - 2;
  localparam logic [ADDR_W-1:0] PAT_LEN_A = ADDR_W'(PAT_LEN);
  localparam logic [ADDR_W-1:0] PL_M1     = ADDR_W'(PAT_LEN - 1);
  localparam logic [ADDR_W:0]   ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic                 find_all_q;
  logic [ADDR_W-1:0]    start_q, len_q;
  logic [2*PAT_LEN-1:0] pattern_q;
  logic [WIN_W-1:0]     window_q;
  logic                 re_q;      // read stream still running
  logic                 vld_q;     // mem_data carries a requested nucleotide
  logic [ADDR_W-1:0]    iss_idx;   // index currently on mem_addr
  logic [ADDR_W-1:0]    cmp_idx;   // index currently on mem_data

  logic [ADDR_W:0]      end_sum;
  logic                 req_err;
  logic [ADDR_W-1:0]    last_idx;
  logic [2*PAT_LEN-1:0] cmp_word;
  logic                 hit;
  logic                 last_cmp;

  // Range check is done one bit wider so start+length = 2^ADDR_W is legal.
  assign end_sum  = {1'b0, start_q} + {1'b0, len_q};
  assign req_err  = (len_q < PAT_LEN_A) || (end_sum > ADDR_SPAN);
  assign last_idx = len_q - ADDR_W'(1);

  assign cmp_word = {window_q, mem_data};
  // Only a full window (index >= PAT_LEN-1) may produce a match.
  assign hit      = (state_q == SCAN) && vld_q && (cmp_idx >= PL_M1) &&
                    (cmp_word == pattern_q);
  assign last_cmp = vld_q && (cmp_idx == last_idx);

  // A first-match stop suppresses the read being issued in the same cycle.
  assign mem_re    = re_q && !(hit && !find_all_q);
  assign fsm_state = state_q;

  // State register
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ready) state_d = CHECK;
      CHECK:   state_d = req_err ? DONE : SCAN;
      SCAN:    if ((hit && !find_all_q) || last_cmp) state_d = DONE;
      DONE:    if (!ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      find_all_q  <= 1'b0;
      start_q     <= '0;
      len_q       <= '0;
      pattern_q   <= '0;
      window_q    <= '0;
      re_q        <= 1'b0;
      vld_q       <= 1'b0;
      iss_idx     <= '0;
      cmp_idx     <= '0;
      mem_addr    <= '0;
      done        <= 1'b0;
      found_it    <= 1'b0;
      error       <= 1'b0;
      match_pos   <= '0;
      match_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready) begin
            find_all_q  <= find_all;
            start_q     <= dna_start;
            len_q       <= dna_length;
            pattern_q   <= pattern;
            found_it    <= 1'b0;
            error       <= 1'b0;
            match_pos   <= '0;
            match_count <= '0;
          end
        end
        CHECK: begin
          iss_idx  <= '0;
          cmp_idx  <= '0;
          window_q <= '0;
          vld_q    <= 1'b0;
          if (req_err) begin
            error <= 1'b1;
            done  <= 1'b1;
          end else begin
            mem_addr <= start_q;
            re_q     <= 1'b1;
          end
        end
        SCAN: begin
          vld_q <= mem_re;
          // The address stays on the last issued index when the stream ends.
          if (mem_re) begin
            if (iss_idx == last_idx) begin
              re_q <= 1'b0;
            end else begin
              iss_idx  <= iss_idx + ADDR_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
          if (vld_q) begin
            window_q <= cmp_word[WIN_W-1:0];
            cmp_idx  <= cmp_idx + ADDR_W'(1);
          end
          if (hit) begin
            if (!found_it) begin
              found_it  <= 1'b1;
              match_pos <= start_q + cmp_idx - PL_M1;
            end
            if (match_count != CNT_MAX) match_count <= match_count + CNT_W'(1);
          end
          if (state_d == DONE) begin
            done  <= 1'b1;
            re_q  <= 1'b0;
            vld_q <= 1'b0;
          end
        end
        DONE: begin
          if (!ready) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_pattern_search.sv
// tb_dna_pattern_search
//
// Bench for dna_pattern_search (PAT_LEN=4). A 64K-entry nucleotide memory with
// synchronous read feeds the DUT. Each search computes its expected results
// from a reference scan of that memory and pushes them to exp_q. They are
// popped and compared once done rises. A monitor counts the reads issued and
// records the last read address.
module tb_dna_pattern_search;

  localparam int AW = 16;
  localparam int PL = 4;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            reset_N;
  logic            ready;
  logic            find_all;
  logic [AW-1:0]   dna_start;
  logic [AW-1:0]   dna_length;
  logic [2*PL-1:0] pattern;
  logic [AW-1:0]   mem_addr;
  logic            mem_re;
  logic [1:0]      mem_data = 2'd0;
  logic            done;
  logic            found_it;
  logic            error;
  logic [AW-1:0]   match_pos;
  logic [CW-1:0]   match_count;
  logic [1:0]      fsm_state;

  logic [1:0]  mem [0:65535];
  logic [15:0] exp_q[$];

  int          checks   = 0;
  int          failures = 0;
  int          rd_count = 0;
  logic [AW-1:0] last_rd = '0;

  // ---------------- clock / reset / memory ----------------
  always #5 clock = ~clock;

  dna_pattern_search #(.ADDR_W(AW), .PAT_LEN(PL), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset_N     (reset_N),
    .ready       (ready),
    .find_all    (find_all),
    .dna_start   (dna_start),
    .dna_length  (dna_length),
    .pattern     (pattern),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_data    (mem_data),
    .done        (done),
    .found_it    (found_it),
    .error       (error),
    .match_pos   (match_pos),
    .match_count (match_count),
    .fsm_state   (fsm_state)
  );

  always @(posedge clock) if (mem_re) mem_data <= mem[mem_addr];

  always @(negedge clock) begin
    if (mem_re === 1'b1) begin
      rd_count++;
      last_rd = mem_addr;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference scan of the bench memory.
  task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] l,
                       input logic [2*PL-1:0] p, input logic fa,
                       output logic e, output logic f, output logic [AW-1:0] pos,
                       output logic [CW-1:0] cnt, output int cyc, output int nrd,
                       output logic [AW-1:0] last);
    logic [2*PL-1:0] w;
    logic [AW:0]     sum;
    e = 1'b0; f = 1'b0; pos = '0; cnt = '0; w = '0;
    sum = {1'b0, s} + {1'b0, l};
    if ((l < AW'(PL)) || (sum > 17'h10000)) begin
      e = 1'b1; cyc = 2; nrd = 0; last = '0;
      return;
    end
    cyc  = int'(l) + 3;
    nrd  = int'(l);
    last = s + l - AW'(1);
    for (int i = 0; i < int'(l); i++) begin
      w = {w[2*PL-3:0], mem[AW'(int'(s) + i)]};
      if (i >= PL - 1 && w == p) begin
        if (!f) begin
          f   = 1'b1;
          pos = AW'(int'(s) + i - (PL - 1));
        end
        cnt = cnt + CW'(1);
        if (!fa) begin
          cyc  = 4 + i;
          nrd  = i + 1;
          last = AW'(int'(s) + i);
          break;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_search(input logic [AW-1:0] s, input logic [AW-1:0] l,
                            input logic [2*PL-1:0] p, input logic fa, input int hold);
    logic          e, f;
    logic [AW-1:0] pos, last;
    logic [CW-1:0] cnt;
    int            cyc, nrd, n, base;
    logic [15:0]   xe;
    model(s, l, p, fa, e, f, pos, cnt, cyc, nrd, last);
    exp_q.push_back({15'd0, e});
    exp_q.push_back({15'd0, f});
    exp_q.push_back(pos);
    exp_q.push_back(cnt);
    exp_q.push_back(16'(cyc));
    exp_q.push_back(16'(nrd));
    if (!e) exp_q.push_back(last);

    @(negedge clock);
    dna_start = s; dna_length = l; pattern = p; find_all = fa; ready = 1'b1;
    base = rd_count;
    @(posedge clock);            // edge 0: request sampled
    n = 1;
    @(negedge clock);
    while (!done && n < 1000) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end

    xe = exp_q.pop_front();
    check("error", error, xe);
    check("found_it", found_it, exp_q.pop_front());
    check("match_pos", match_pos, exp_q.pop_front());
    check("match_count", match_count, exp_q.pop_front());
    check("done_cycle", n, exp_q.pop_front());
    check("reads", rd_count - base, exp_q.pop_front());
    if (xe[0] == 1'b0) check("last_addr", last_rd, exp_q.pop_front());

    // ready kept high through DONE must not start another search
    if (hold > 0) begin
      repeat (hold) @(negedge clock);
      check("hold_done", done, 1);
      check("hold_reads", rd_count - base, nrd);
    end

    ready = 1'b0;
    @(negedge clock);
    check("idle_done", done, 0);
    check("idle_state", fsm_state, 0);
    check("idle_found", found_it, f);
    check("idle_count", match_count, cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b2;
    reset_N = 1'b0; ready = 1'b0; find_all = 1'b0;
    dna_start = '0; dna_length = '0; pattern = '0;

    // Random background without nucleotide 3, so 3-led patterns match
    // only where they are placed explicitly.
    for (int i = 0; i < 65536; i++) mem[i] = 2'($urandom_range(0, 2));
    mem[10] = 2'd3; mem[11] = 2'd2; mem[12] = 2'd1; mem[13] = 2'd0;
    mem[30] = 2'd3; mem[31] = 2'd2; mem[32] = 2'd1; mem[33] = 2'd0;
    for (int i = 100; i < 106; i++) mem[i] = 2'd0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_done", done, 0);
    check("rst_found", found_it, 0);
    check("rst_error", error, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_match_pos", match_pos, 0);
    check("rst_match_count", match_count, 0);
    check("rst_state", fsm_state, 0);
    reset_N = 1'b1;

    run_search(16'd0,     16'd45,    8'hE4, 1'b0, 0);  // first match at 10
    run_search(16'd0,     16'd45,    8'hE4, 1'b1, 6);  // both matches, ready held
    run_search(16'd0,     16'd45,    8'hFF, 1'b0, 0);  // no match, full scan
    run_search(16'd100,   16'd6,     8'h00, 1'b1, 0);  // overlapping matches
    run_search(16'd0,     16'd3,     8'hE4, 1'b0, 0);  // too short
    run_search(16'hFFF0,  16'h0020,  8'hE4, 1'b1, 0);  // past top of memory
    run_search(16'hFFF0,  16'h0010,  8'hE4, 1'b1, 0);  // ends exactly at top
    run_search(16'd40,    16'd4,     {mem[40], mem[41], mem[42], mem[43]}, 1'b0, 0);

    for (int k = 0; k < 4; k++) begin
      logic [2*PL-1:0] rp;
      rp = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
            2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      run_search(AW'($urandom_range(0, 300)), AW'($urandom_range(4, 120)), rp,
                 1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of a scan
    @(negedge clock);
    dna_start = 16'd0; dna_length = 16'd45; pattern = 8'hE4; find_all = 1'b1;
    ready = 1'b1;
    repeat (8) @(posedge clock);
    #2 reset_N = 1'b0;
    #1;
    check("mid_rst_done", done, 0);
    check("mid_rst_found", found_it, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_mem_re", mem_re, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_match_pos", match_pos, 0);
    check("mid_rst_match_count", match_count, 0);
    check("mid_rst_state", fsm_state, 0);
    b2 = rd_count;
    ready = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_rst_no_reads", rd_count - b2, 0);
    reset_N = 1'b1;

    // Recovery after reset
    run_search(16'd0, 16'd45, 8'hE4, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dna_pattern_search.md
Name: dna_pattern_search

Overview:
- Parametrised successor to the lab5 pattern search machine: scans a nucleotide sequence (2 bits per nucleotide, one nucleotide per address) in an external synchronous-read memory for a PAT_LEN-nucleotide pattern.
- Adds a selectable find-first / find-all mode, overlapping-match counting, match position reporting and address-overflow detection.
- Sits between the lab memory and the top-level control that raises ready.

Parameters:
- ADDR_W, 16, memory address and length width.
- PAT_LEN, 8, pattern length in nucleotides (2..16).
- CNT_W, 16, match counter width.

Ports:
- clock  input  1  system clock, rising edge.
- reset_N  input  1  asynchronous active-low reset.
- ready  input  1  start request, sampled in IDLE.
- find_all  input  1  0 = stop at first match; 1 = scan whole sequence.
- dna_start  input  ADDR_W  address of nucleotide 0.
- dna_length  input  ADDR_W  number of nucleotides to scan.
- pattern  input  2*PAT_LEN  pattern; bits [1:0] are the last nucleotide, MS pair is the first.
- mem_addr  output  ADDR_W  read address.
- mem_re  output  1  read enable; data valid on mem_data exactly one cycle later.
- mem_data  input  2  nucleotide read data.
- done  output  1  search complete; held while in DONE.
- found_it  output  1  at least one match found.
- error  output  1  invalid request.
- match_pos  output  ADDR_W  address of the first nucleotide of the first match.
- match_count  output  CNT_W  number of matches, overlapping matches included.

Behaviour:
- Reset (async, any state): state=IDLE; done, found_it, error, mem_re=0; mem_addr, match_pos, match_count=0; window register and counters cleared. Reset mid-scan abandons the scan with no further reads.
- States:
  - IDLE -> CHECK when ready=1. On the same edge, latch find_all, dna_start, dna_length and pattern, and clear found_it, error, match_pos and match_count.
  - CHECK, 1 cycle: error if dna_length < PAT_LEN, or if dna_start + dna_length > 2^ADDR_W (compute with ADDR_W+1 bits). Error -> DONE with error=1 and no memory read. Otherwise -> SCAN.
  - SCAN:
    - Issue index i (0-based) at mem_addr = dna_start + i with mem_re=1, one per cycle, i = 0..dna_length-1.
    - The cycle after index i is issued, compare {window[2*PAT_LEN-3:0], mem_data} against the latched pattern, qualified by nucleotides received >= PAT_LEN. On that edge, shift mem_data into the window.
    - On a match at index i: position = dna_start + i - PAT_LEN + 1. If found_it=0, load match_pos and set found_it. Increment match_count, saturating at 2^CNT_W-1.
    - find_all=0 and match -> DONE on that edge. Reads already issued are discarded.
    - Otherwise -> DONE on the edge that compares the last index.
  - DONE: done=1 and mem_re=0; all result outputs held. -> IDLE when ready=0. Results stay valid in IDLE until the next accepted ready.
- ready=1 held continuously: a new search is not started until ready has been seen low in DONE.
- Timing: ready sampled at edge 0. CHECK is cycle 1. Index i is issued in cycle 2+i and compared in cycle 3+i. done rises in cycle 4+i for a first match at i, or cycle L+3 for a full scan of length L. Error: done rises in cycle 2.
- Ports that are not inputs change only on clock edges or on reset.

Test Plan:
- Memory 0x0000-0x002C (L=45) random, with pattern 8'hE4-derived PAT_LEN=4 pattern {3,2,1,0} placed at addresses 10 and 30; dna_start=0, find_all=0 -> found_it=1, match_pos=10, match_count=1, done in cycle 17, no read issued after address 13.
- Same memory, find_all=1 -> found_it=1, match_pos=10, match_count=2, done in cycle 48, last mem_addr=44.
- Memory all 0, pattern all 0, PAT_LEN=4, L=6, find_all=1 -> match_count=3 (overlapping), match_pos=dna_start.
- dna_length=3 with PAT_LEN=4 -> error=1, done in cycle 2, mem_re never asserted.
- dna_start=16'hFFF0, dna_length=16'h0020 -> error=1, found_it=0. dna_start=16'hFFF0, dna_length=16'h0010 -> no error, last address 16'hFFFF.
- reset_N pulsed low mid-SCAN -> all outputs 0 immediately. Then ready with ready held high through DONE -> exactly one search; a second search starts only after ready drops and rises again.
